// File: rtl/alu_operand_stage.sv
// Operand-fetch stage for the 32-bit AND/OR logic unit: register file, two read
// lanes with write-back bypass, and a single valid/ready output register.

module alu_operand_lane #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_hold,
  input  logic [AW-1:0]     i_rs,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic              i_wb_valid,
  input  logic [AW-1:0]     i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data
);
  logic [DATA_W-1:0] r_data;
  logic [AW-1:0]     r_rs;
  logic              w_hit_rd;
  logic              w_hit_held;
  logic [DATA_W-1:0] w_fetch;

  // Index 0 never bypasses, so a write-back aimed at it cannot leak into an operand.
  assign w_hit_rd   = i_wb_valid && (i_wb_rd == i_rs) && (i_rs != '0);
  assign w_hit_held = i_wb_valid && (i_wb_rd == r_rs) && (r_rs != '0);
  assign w_fetch    = w_hit_rd ? i_wb_data : i_rf_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rs   <= '0;
    end else if (i_load) begin
      r_data <= w_fetch;
      r_rs   <= i_rs;
    end else if (i_hold && w_hit_held) begin
      r_data <= i_wb_data;
    end
  end

  assign o_data = r_data;
endmodule

module alu_operand_stage #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_op,
  output logic [AW-1:0]     out_rd,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data
);
  localparam int NUM_OPS = 2;

  logic [DATA_W-1:0]              r_regs [NREGS];
  logic                           r_out_valid;
  logic                           r_op;
  logic [AW-1:0]                  r_rd;
  logic                           w_fire;
  logic                           w_stall;
  logic [NUM_OPS-1:0][AW-1:0]     w_rs;
  logic [NUM_OPS-1:0][DATA_W-1:0] w_rf_data;
  logic [NUM_OPS-1:0][DATA_W-1:0] w_opnd;

  assign in_ready = !r_out_valid || out_ready;
  assign w_fire   = in_valid && in_ready;
  assign w_stall  = r_out_valid && !out_ready;

  // Register 0 is reset to zero and never written, so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_valid && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  assign w_rs[0] = in_rs1;
  assign w_rs[1] = in_rs2;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_lane
    assign w_rf_data[g] = r_regs[w_rs[g]];
    alu_operand_lane #(.DATA_W(DATA_W), .AW(AW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_fire),
      .i_hold    (w_stall),
      .i_rs      (w_rs[g]),
      .i_rf_data (w_rf_data[g]),
      .i_wb_valid(wb_valid),
      .i_wb_rd   (wb_rd),
      .i_wb_data (wb_data),
      .o_data    (w_opnd[g])
    );
  end

  // Occupancy bit: load wins over drain, drain without load empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_op        <= 1'b0;
      r_rd        <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_op        <= in_op;
      r_rd        <= in_rd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_a     = w_opnd[0];
  assign out_b     = w_opnd[1];
  assign out_op    = r_op;
  assign out_rd    = r_rd;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: table-driven streaming with a scoreboard queue,
// plus hand-written stall, held-update and async-reset sequences.

module tb_alu_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_op;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          out_valid, out_ready, out_op;
  logic [DW-1:0] out_a, out_b;
  logic [AW-1:0] out_rd;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  alu_operand_stage #(.DATA_W(DW), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rs1, rs2, rd;
    logic          op;
    logic          wbv;
    logic [AW-1:0] wbrd;
    logic [DW-1:0] wbd, ea, eb;
  } vec_t;

  typedef struct {
    logic [DW-1:0] a, b;
    logic          op;
    logic [AW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  vec_t vt[13];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [DW-1:0] sval(input int r);
    return 32'hA500_0000 ^ (r * 32'h0001_0203);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pops the scoreboard on every handshake, then advances one edge.
  task automatic cycle();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_a", out_a, e.a);
        chk("sb_b", out_b, e.b);
        chk("sb_op", {31'd0, out_op}, {31'd0, e.op});
        chk("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    cycle();
    wb_valid = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic op, input logic [AW-1:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rd = rd;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{5'd3, 5'd5, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0, 32'hF0F0_1234, 32'h0FF0_FFFF};
    vt[1] = '{5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0};
    vt[2] = '{5'd4, 5'd4, 5'd2, 1'b0, 1'b1, 5'd4, 32'h1111_2222, 32'h1111_2222, 32'h1111_2222};
    vt[3] = '{5'd4, 5'd3, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0, 32'h1111_2222, 32'hF0F0_1234};
    vt[4] = '{5'd0, 5'd5, 5'd4, 1'b0, 1'b1, 5'd0, 32'h0000_1234, 32'h0, 32'h0FF0_FFFF};
    for (int k = 0; k < 8; k++)
      vt[5+k] = '{5'(8+k), 5'(15-k), 5'(16+k), 1'(k), 1'b0, 5'd0, 32'h0, sval(8+k), sval(15-k)};

    rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_op = 1'b0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_op_rd", {26'd0, out_op, out_rd}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    wb(5'd3, 32'hF0F0_1234);
    wb(5'd5, 32'h0FF0_FFFF);
    wb(5'd0, 32'hDEAD_BEEF);
    wb(5'd6, 32'hAAAA_AAAA);
    for (int r = 8; r < 16; r++) wb(5'(r), sval(r));

    // Back-to-back table: one accept per cycle, no bubbles.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_rs1 = vt[i].rs1; in_rs2 = vt[i].rs2;
      in_rd = vt[i].rd; in_op = vt[i].op;
      wb_valid = vt[i].wbv; wb_rd = vt[i].wbrd; wb_data = vt[i].wbd;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      push(vt[i].ea, vt[i].eb, vt[i].op, vt[i].rd);
      cycle();
      chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0; wb_valid = 1'b0;
    cycle();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_hold_a", out_a, sval(15));

    // Stall with held-operand update.
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd6; in_rs2 = 5'd3; in_rd = 5'd9; in_op = 1'b0;
    cycle();
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_a_old", out_a, 32'hAAAA_AAAA);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    in_rs1 = 5'd5; in_rs2 = 5'd6; in_rd = 5'd11; in_op = 1'b1;
    wb(5'd6, 32'h5555_5555);
    chk("held_a_upd", out_a, 32'h5555_5555);
    chk("held_b_keep", out_b, 32'hF0F0_1234);
    chk("held_valid", {31'd0, out_valid}, 32'd1);
    chk("held_in_ready", {31'd0, in_ready}, 32'd0);
    chk("held_rd_stable", {27'd0, out_rd}, 32'd9);
    wb(5'd3, 32'h3333_0000);
    chk("held_b_upd", out_b, 32'h3333_0000);
    chk("held_a_keep", out_a, 32'h5555_5555);

    // Drain and accept in the same cycle.
    push(32'h5555_5555, 32'h3333_0000, 1'b0, 5'd9);
    push(32'h0FF0_FFFF, 32'h5555_5555, 1'b1, 5'd11);
    out_ready = 1'b1;
    cycle();
    chk("swap_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    cycle();
    chk("swap_drained", {31'd0, out_valid}, 32'd0);

    // Async reset while FULL and stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd3; in_rd = 5'd12; in_op = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_a", out_a, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd3; in_rd = 5'd13; in_op = 1'b0;
    push(32'd0, 32'd0, 1'b0, 5'd13);
    cycle();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    cycle();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch pipeline stage that sits directly upstream of the 32-bit AND/OR logic unit. Holds the architectural register file, reads two source registers per accepted instruction, and presents registered operands `a`, `b` and the `op` select to the logic unit through a valid/ready handshake. Accepts a write-back port carrying results returned from downstream, and forwards them into both the read path and any operands currently held in the output register.

## Interface
Parameters:
- `DATA_W`, 32, operand and register width; must match the logic unit's 32-bit operands.
- `NREGS`, 32, number of registers; power of two, at least 2.
- `AW`, $clog2(NREGS), register index width (derived; not overridden).

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream instruction valid.
- `in_ready`  output  1  stage can accept an instruction this cycle.
- `in_rs1`  input  AW  source register index for `a`.
- `in_rs2`  input  AW  source register index for `b`.
- `in_rd`  input  AW  destination index, passed through.
- `in_op`  input  1  0 = AND, 1 = OR, passed through.
- `out_valid`  output  1  `out_a`/`out_b`/`out_op`/`out_rd` hold a valid instruction.
- `out_ready`  input  1  downstream consumes the instruction this cycle.
- `out_a`  output  DATA_W  operand to logic unit `a`.
- `out_b`  output  DATA_W  operand to logic unit `b`.
- `out_op`  output  1  to logic unit `op`.
- `out_rd`  output  AW  destination index accompanying the result.
- `wb_valid`  input  1  write-back strobe.
- `wb_rd`  input  AW  write-back register index.
- `wb_data`  input  DATA_W  write-back value.

## Operation
- Register file: NREGS × DATA_W. Register 0 always reads 0; writes to index 0 are discarded.
- Write: when `wb_valid` and `wb_rd != 0`, `regs[wb_rd] <= wb_data` at the clock edge.
- Accept: the fire condition is `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, combinational, with a single output register and no skid buffer.
- On accept, the stage latches the operands:
  - `out_a <= (wb_valid && wb_rd == in_rs1 && in_rs1 != 0) ? wb_data : regs[in_rs1]`.
  - `out_b` uses the same rule with `in_rs2`.
  - `out_op`, `out_rd` and the internal copies `held_rs1` and `held_rs2` are latched.
  - `out_valid <= 1`.
- Held-operand update: while `out_valid && !out_ready` and no accept occurs, a write-back with a nonzero `wb_rd` equal to `held_rs1` replaces `out_a` with `wb_data` at the edge. The same applies to `held_rs2` and `out_b`. Both update if both match.
- Drain: when `out_valid && out_ready` and no accept occurs, `out_valid <= 0`. Data outputs hold their last value.
- Simultaneous accept and drain: new data is loaded and `out_valid` stays 1.
- Simultaneous write and read of the same index: the read returns the new value, through the bypass.
- Output stability: `out_a`, `out_b`, `out_op` and `out_rd` change while `out_valid && !out_ready` only through the held-operand update.

## Timing
- Reset, asserted asynchronously: all registers are 0. Outputs are `out_valid=0`, `out_a=0`, `out_b=0`, `out_op=0`, `out_rd=0`, and `held_rs1`/`held_rs2` are 0. `in_ready` is therefore 1 during and after reset.
- Reset mid-operation: a held instruction is dropped and the register contents are lost. The first edge after `rst_n` rises may accept an instruction.
- Latency: an instruction accepted at edge N appears with `out_valid=1` after edge N. The throughput is 1 instruction per cycle while `out_ready=1`.
- Write-back is visible to a read issued in the same cycle via the bypass, and to the register file from the next cycle.
- The stage has no internal state machine beyond the `out_valid` occupancy bit, which has two states, EMPTY and FULL:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on a stall, or on drain with accept.

## Test plan
- Reset then fetch: write `regs[3]=0xF0F0_1234` and `regs[5]=0x0FF0_FFFF`, then issue rs1=3, rs2=5, op=1, rd=7. Required: `out_a=0xF0F0_1234`, `out_b=0x0FF0_FFFF`, `out_op=1`, `out_rd=7` one cycle later, and `out_valid=1`.
- Zero register: write 0xDEAD_BEEF to index 0, then read rs1=0, rs2=0. Required: `out_a=0`, `out_b=0`.
- Same-cycle bypass: `wb_rd=4`, `wb_data=0x1111_2222` in the same cycle as an accept with rs1=4, rs2=4. Required: `out_a=out_b=0x1111_2222`.
- Stall with held update: hold `out_ready=0` after accepting rs1=6 (old value 0xAAAA_AAAA), then write back `regs[6]=0x5555_5555`. Required: `out_a` becomes 0x5555_5555 on the next edge, `out_valid` stays 1, and `in_ready=0`.
- Back-to-back streaming: 8 instructions with `in_valid=1` and `out_ready=1` continuously. Required: 8 consecutive `out_valid` cycles with correct operands in order, and no bubbles.
- Async reset mid-stall: pull `rst_n` low between edges while FULL. Required: `out_valid=0` and `out_a=0` immediately, without waiting for a clock edge, and a subsequent read of any register returns 0.
